am_tx_bip: RTL and testbench
============================

# am_tx_bip

Parametrised PCS-lane alignment marker inserter for the TX pipe, sitting between the scrambler/encoder outputs and the gearbox. It counts blocks per lane, replaces one block slot every `AM_GAP`+1 blocks with a per-lane alignment marker, and stalls upstream for that slot. It also computes the real BIP3/BIP7 bytes per lane: the bit-interleaved parity over every block since, and including, the previous marker. Lane count, marker spacing and marker encodings are all parameters.

## Interface
- `LANE_N`, 4: number of PCS lanes.
- `HEAD_W`, 2: sync header width; fixed at 2 for BIP mapping.
- `DATA_W`, 64: block payload width; fixed at 64 for BIP mapping.
- `AM_GAP`, 16383: data blocks between two markers.
- `CNT_W`, `$clog2(AM_GAP)`: counter width (derived).
- `MARKER`, package default for 40G: `LANE_N`*48-bit vector, 6 fixed bytes per lane, lane 0 in the LSBs.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `valid_i` in 1: gearbox accepts a block slot this cycle.
- `head_i` in `LANE_N`*`HEAD_W`: encoder sync headers.
- `data_i` in `LANE_N`*`DATA_W`: scrambled payloads.
- `marker_v_o` out 1: the current slot is a marker slot; upstream must hold its data.
- `valid_o` out 1: `head_o`/`data_o` were updated last cycle.
- `head_o` out `LANE_N`*`HEAD_W`: output headers, registered.
- `data_o` out `LANE_N`*`DATA_W`: output payloads, registered.

## Operation
- **State:** `cnt_q` (`CNT_W` bits), `marker_q` (1 bit), a per-lane 8-bit parity accumulator `acc_q`, and the output registers.
- **Gating:** every state update is gated by `valid_i`. With `valid_i` low, all registers hold and `valid_o` is 0.
- **Data slot** (`valid_i` and not `marker_q`):
  - Output = input block.
  - `acc_q` ^= BIP(input block).
  - If `cnt_q` == `AM_GAP`-1: `cnt_q` <= 0 and `marker_q` <= 1. Otherwise `cnt_q`+1.
- **Marker slot** (`valid_i` and `marker_q`):
  - `data_i`/`head_i` are ignored.
  - Per lane L, the marker is built as follows:
    - `head_o` = 2'b01 (control).
    - Bytes 0..2 = `MARKER` bytes 0..2.
    - Byte 3 = BIP3 = `acc_q`.
    - Bytes 4..6 = `MARKER` bytes 3..5.
    - Byte 7 = BIP7 = ~`acc_q`.
  - `acc_q` <= BIP(emitted marker), so the next marker's parity includes this marker.
  - `marker_q` <= 0.
- **BIP(block):** 8-bit value.
  - Bit k = XOR of `data` bits j with j mod 8 == k.
  - Bit 3 additionally XORs `head[0]`; bit 4 additionally XORs `head[1]`.
  - This equals block bit b feeding BIP bit (b-2) mod 8, with sync bits 0 and 1 feeding BIP bits 3 and 4.
- **Period:** `AM_GAP` data slots then 1 marker slot. The first marker comes after `AM_GAP` data slots following reset.
- `marker_v_o` = `marker_q`, combinational from the register.

## Timing
- **Reset:** `cnt_q`=0, `marker_q`=0, `acc_q`=0, `valid_o`=0, `head_o`=0, `data_o`=0, `marker_v_o`=0.
- **Latency:** 1 cycle, from the `valid_i` slot to `head_o`/`data_o`/`valid_o`.
- **Stall:** `marker_v_o` is high for the whole marker slot, including cycles where `valid_i` is low. It drops the cycle after the accepted marker slot.
- **Wrap:** `cnt_q` never exceeds `AM_GAP`-1. No overflow arithmetic is relied upon.
- **Reset mid-period:** the count restarts and accumulators clear; a pending marker is dropped.
- **Reset and `valid_i` in the same cycle:** reset wins.

## Configuration
- **`AM_TX_GAP_CFG_EN` defined:**
  - Adds input port `gap_i` (`CNT_W` bits).
  - The marker period uses `gap_i` instead of `AM_GAP` (wrap at `gap_i`-1; a value of 0 is treated as 1).
  - `gap_i` is sampled at each wrap; this is for short-period simulation and bring-up.
- **Undefined:** no port; the period is the constant `AM_GAP`.

## Structure
- **Package `am_pkg`:**
  - `AM_CTRL_HEAD` = 2'b01.
  - `AM_GAP_DEFAULT` = 16383.
  - 40G marker bytes per lane:
    - Lane 0: 90,76,47 / 6F,89,B8
    - Lane 1: F0,C4,E6 / 0F,3B,19
    - Lane 2: C5,65,9B / 3A,9A,64
    - Lane 3: A2,79,3D / 5D,86,C2
  - A `bip8` function.
- **Sub-module `am_lane_bip_tx`:** one instance per lane. It holds the accumulator, the marker build, the output mux and the output registers. The shared counter and `marker_q` stay in the top module.

## Test plan
- **Period:** `AM_GAP`=4, `valid_i` constantly high -> `marker_v_o` high every 5th cycle; the first marker slot is the 5th accepted slot; `valid_o` follows one cycle later.
- **Reset BIP:** `AM_GAP`=4, data all-zero, `head_i` 2'b10 -> first lane-0 marker reads 90,76,47,00,6F,89,B8,FF with head 01.
- **Marker in parity:** same stimulus continued -> second lane-0 marker has BIP3=0x08, BIP7=0xF7 (marker bytes XOR to 0x00, plus control `head[0]` into bit 3).
- **Backpressure:** `valid_i` low for 3 cycles inside a marker slot -> `marker_v_o` stays high, `cnt_q`/`acc_q` unchanged, the marker is emitted once when `valid_i` returns.
- **Reset mid-period:** `reset` after 2 data slots -> the next marker appears only after 4 more data slots, with BIP3=0x00.
- **`LANE_N`=20 with random data:** each lane's BIP3 matches the reference model computed per lane, and lanes stay independent.

Source files
------------

// File: rtl/am_pkg.sv
// Shared constants and helpers for the TX alignment-marker inserter:
// control sync header, default marker spacing, 40G lane markers and BIP-8.
package am_pkg;

   localparam logic [1:0] AM_CTRL_HEAD   = 2'b01;
   localparam int         AM_GAP_DEFAULT = 16383;

   // 40G markers, 6 bytes per lane, byte 0 in the LSBs, lane 0 in the LSBs.
   localparam logic [191:0] AM_MARKER_40G = {
      48'hC2865D3D79A2,   // lane 3: A2,79,3D / 5D,86,C2
      48'h649A3A9B65C5,   // lane 2: C5,65,9B / 3A,9A,64
      48'h193B0FE6C4F0,   // lane 1: F0,C4,E6 / 0F,3B,19
      48'hB8896F477690    // lane 0: 90,76,47 / 6F,89,B8
   };

   // Bit-interleaved parity of one 66-bit block. Payload bit j lands in
   // parity bit j mod 8; the two sync bits land in parity bits 3 and 4.
   function automatic logic [7:0] bip8(input logic [1:0] head, input logic [63:0] data);
      logic [7:0] p;
      p = 8'h00;
      for (int j = 0; j < 64; j++) begin
         p[j % 8] = p[j % 8] ^ data[j];
      end
      p[3] = p[3] ^ head[0];
      p[4] = p[4] ^ head[1];
      return p;
   endfunction

endpackage

// File: rtl/am_lane_bip_tx.sv
// One PCS lane of the marker inserter: BIP accumulator, marker block
// build, data/marker output mux and the registered lane outputs.
module am_lane_bip_tx
   import am_pkg::*;
#(
   parameter int          HEAD_W = 2,
   parameter int          DATA_W = 64,
   parameter logic [47:0] MARK   = 48'hB8896F477690
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_i,
   input  logic              marker_i,
   input  logic [HEAD_W-1:0] head_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [HEAD_W-1:0] head_o,
   output logic [DATA_W-1:0] data_o
);

   logic [7:0]        acc_q;
   logic [HEAD_W-1:0] mk_head;
   logic [DATA_W-1:0] mk_data;
   logic [HEAD_W-1:0] sel_head;
   logic [DATA_W-1:0] sel_data;
   logic [7:0]        sel_bip;

   // Marker block: three fixed bytes, BIP3, three fixed bytes, BIP7.
   assign mk_head = AM_CTRL_HEAD;
   assign mk_data = {~acc_q, MARK[47:24], acc_q, MARK[23:0]};

   // Output mux: the marker replaces the upstream block in a marker slot.
   always_comb begin
      sel_head = head_i;
      sel_data = data_i;
      if (marker_i) begin
         sel_head = mk_head;
         sel_data = mk_data;
      end
   end

   assign sel_bip = bip8(sel_head, sel_data);

   // Slot register: outputs and parity advance only on accepted slots;
   // a marker restarts the parity with its own contribution.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q  <= 8'h00;
         head_o <= '0;
         data_o <= '0;
      end else if (valid_i) begin
         head_o <= sel_head;
         data_o <= sel_data;
         acc_q  <= marker_i ? sel_bip : (acc_q ^ sel_bip);
      end
   end

endmodule

// File: rtl/am_tx_bip.sv
// TX alignment-marker inserter with per-lane BIP3/BIP7. Replaces one slot
// every AM_GAP+1 accepted slots with a per-lane marker and flags the slot
// on marker_v_o so upstream holds its block.
// Optional build macro AM_TX_GAP_CFG_EN: adds gap_i, a run-time marker
// spacing (0 behaves as 1) that overrides AM_GAP.
module am_tx_bip
   import am_pkg::*;
#(
   parameter int                   LANE_N = 4,
   parameter int                   HEAD_W = 2,
   parameter int                   DATA_W = 64,
   parameter int                   AM_GAP = AM_GAP_DEFAULT,
   parameter int                   CNT_W  = (AM_GAP > 1) ? $clog2(AM_GAP) : 1,
   parameter logic [LANE_N*48-1:0] MARKER = {((LANE_N + 3) / 4){AM_MARKER_40G}}
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       valid_i,
`ifdef AM_TX_GAP_CFG_EN
   input  logic [CNT_W-1:0]           gap_i,
`endif
   input  logic [LANE_N*HEAD_W-1:0]   head_i,
   input  logic [LANE_N*DATA_W-1:0]   data_i,
   output logic                       marker_v_o,
   output logic                       valid_o,
   output logic [LANE_N*HEAD_W-1:0]   head_o,
   output logic [LANE_N*DATA_W-1:0]   data_o
);

   logic [CNT_W-1:0] cnt_q;
   logic             marker_q;
   logic             valid_q;
   logic             wrap;

`ifdef AM_TX_GAP_CFG_EN
   logic [CNT_W-1:0] cnt_last;
   // A shrinking gap_i must still wrap, so compare with >= rather than ==.
   assign cnt_last = (gap_i == '0) ? '0 : (gap_i - 1'b1);
   assign wrap     = (cnt_q >= cnt_last);
`else
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AM_GAP - 1);
   assign wrap = (cnt_q == CNT_LAST);
`endif

   // Period control: count data slots, arm the marker at the wrap and
   // clear it once the marker slot has been accepted.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q    <= '0;
         marker_q <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         valid_q <= valid_i;
         if (valid_i) begin
            if (marker_q) begin
               marker_q <= 1'b0;
            end else if (wrap) begin
               cnt_q    <= '0;
               marker_q <= 1'b1;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end
      end
   end

   assign marker_v_o = marker_q;
   assign valid_o    = valid_q;

   for (genvar l = 0; l < LANE_N; l++) begin : g_lane
      am_lane_bip_tx #(
         .HEAD_W (HEAD_W),
         .DATA_W (DATA_W),
         .MARK   (MARKER[l*48 +: 48])
      ) u_lane (
         .clk      (clk),
         .reset    (reset),
         .valid_i  (valid_i),
         .marker_i (marker_q),
         .head_i   (head_i[l*HEAD_W +: HEAD_W]),
         .data_i   (data_i[l*DATA_W +: DATA_W]),
         .head_o   (head_o[l*HEAD_W +: HEAD_W]),
         .data_o   (data_o[l*DATA_W +: DATA_W])
      );
   end

endmodule

// File: tb/tb_am_tx_bip.sv
// Bench for am_tx_bip: 20 lanes, marker every 5th slot, directed period /
// parity / backpressure / reset checks followed by randomized traffic,
// all compared against a slot-position reference model.
module tb_am_tx_bip;

   localparam int LANE_N = 20;
   localparam int HEAD_W = 2;
   localparam int DATA_W = 64;
   localparam int AM_GAP = 4;
`ifdef AM_TX_GAP_CFG_EN
   localparam int CNT_W  = 3;
`else
   localparam int CNT_W  = 2;
`endif

   // Lanes 0..3 carry the 40G markers; the rest get distinct made-up bytes.
   function automatic logic [47:0] mk_lane(input int l);
      logic [47:0] m;
      m = 48'h0;
      case (l)
         0: m = 48'hB8896F477690;
         1: m = 48'h193B0FE6C4F0;
         2: m = 48'h649A3A9B65C5;
         3: m = 48'hC2865D3D79A2;
         default: for (int k = 0; k < 6; k++) m[8*k +: 8] = 8'(l*11 + k*37 + 5);
      endcase
      return m;
   endfunction

   function automatic logic [LANE_N*48-1:0] mk_all();
      logic [LANE_N*48-1:0] v;
      v = '0;
      for (int l = 0; l < LANE_N; l++) v[l*48 +: 48] = mk_lane(l);
      return v;
   endfunction

   localparam logic [LANE_N*48-1:0] MARKER_TB = mk_all();

   // Parity of a 66-bit block: payload bit b (block bit b+2) feeds parity
   // bit (b+2-2) mod 8, sync bits feed parity bits 3 and 4.
   function automatic logic [7:0] bip_ref(input logic [1:0] h, input logic [63:0] d);
      logic [65:0] blk;
      logic [7:0]  p;
      blk = {d, h};
      p   = 8'h00;
      for (int b = 2; b < 66; b++) p[(b - 2) % 8] ^= blk[b];
      p[3] ^= blk[0];
      p[4] ^= blk[1];
      return p;
   endfunction

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      vin;
   logic [LANE_N*HEAD_W-1:0]  hin;
   logic [LANE_N*DATA_W-1:0]  din;
   logic                      mv;
   logic                      vout;
   logic [LANE_N*HEAD_W-1:0]  hout;
   logic [LANE_N*DATA_W-1:0]  dout;
`ifdef AM_TX_GAP_CFG_EN
   logic [CNT_W-1:0]          gap = CNT_W'(AM_GAP);
`endif

   always #5 clk = ~clk;

   am_tx_bip #(
      .LANE_N (LANE_N),
      .HEAD_W (HEAD_W),
      .DATA_W (DATA_W),
      .AM_GAP (AM_GAP),
      .CNT_W  (CNT_W),
      .MARKER (MARKER_TB)
   ) dut (
      .clk        (clk),
      .reset      (rst),
      .valid_i    (vin),
`ifdef AM_TX_GAP_CFG_EN
      .gap_i      (gap),
`endif
      .head_i     (hin),
      .data_i     (din),
      .marker_v_o (mv),
      .valid_o    (vout),
      .head_o     (hout),
      .data_o     (dout)
   );

   int n_cmp = 0;
   int n_bad = 0;
   logic chk_en = 1'b0;

   task automatic chk(input string nm, input int lane, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s lane %0d: got %h, want %h (t=%0t)", nm, lane, act, exp, $time);
      end
   endtask

   // Reference model: position within the period plus per-lane parity.
   int                        slot;
   logic [7:0]                par [LANE_N];
   logic                      exp_v;
   logic                      exp_mv;
   logic [LANE_N*HEAD_W-1:0]  exp_h;
   logic [LANE_N*DATA_W-1:0]  exp_d;

   always @(posedge clk) begin : model
      logic [47:0] m;
      logic [63:0] blk;
      if (rst) begin
         slot  = 0;
         exp_v = 1'b0;
         exp_h = '0;
         exp_d = '0;
         for (int l = 0; l < LANE_N; l++) par[l] = 8'h00;
      end else if (vin) begin
         if (slot == AM_GAP) begin
            for (int l = 0; l < LANE_N; l++) begin
               m   = mk_lane(l);
               blk = {~par[l], m[47:24], par[l], m[23:0]};
               exp_h[l*2 +: 2]   = 2'b01;
               exp_d[l*64 +: 64] = blk;
               par[l] = bip_ref(2'b01, blk);
            end
            slot = 0;
         end else begin
            for (int l = 0; l < LANE_N; l++) begin
               exp_h[l*2 +: 2]   = hin[l*2 +: 2];
               exp_d[l*64 +: 64] = din[l*64 +: 64];
               par[l] = par[l] ^ bip_ref(hin[l*2 +: 2], din[l*64 +: 64]);
            end
            slot++;
         end
         exp_v = 1'b1;
      end else begin
         exp_v = 1'b0;
      end
      exp_mv = (slot == AM_GAP);
   end

   // Compare every cycle on the falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("valid_o", 0, 64'(vout), 64'(exp_v));
         chk("marker_v_o", 0, 64'(mv), 64'(exp_mv));
         for (int l = 0; l < LANE_N; l++) begin
            chk("head_o", l, 64'(hout[l*2 +: 2]), 64'(exp_h[l*2 +: 2]));
            chk("data_o", l, dout[l*64 +: 64], exp_d[l*64 +: 64]);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      vin = 1'b0;
      hin = '0;
      din = '0;
      tick();
      tick();
      chk_en = 1'b1;
      chk("rst valid_o", 0, 64'(vout), 64'h0);
      chk("rst marker_v_o", 0, 64'(mv), 64'h0);
      chk("rst head_o", 0, 64'(hout[1:0]), 64'h0);
      chk("rst data_o", 0, dout[63:0], 64'h0);

      // Period: four data slots, then the marker slot.
      rst = 1'b0;
      vin = 1'b1;
      hin = {LANE_N{2'b10}};
      din = '0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("period marker_v_o", 0, 64'(mv), (i == 3) ? 64'h1 : 64'h0);
      end
      tick();
      chk("first marker valid_o", 0, 64'(vout), 64'h1);
      chk("first marker marker_v_o", 0, 64'(mv), 64'h0);
      chk("first marker head", 0, 64'(hout[1:0]), 64'h1);
      chk("first marker data", 0, dout[63:0], 64'hFFB8896F00477690);
      chk("first marker data", 1, dout[127:64], 64'hFF193B0F00E6C4F0);

      // Second marker carries the first marker's parity.
      repeat (4) tick();
      chk("second period marker_v_o", 0, 64'(mv), 64'h1);
      tick();
      chk("second marker data", 0, dout[63:0], 64'hF7B8896F08477690);

      // Backpressure inside a marker slot.
      repeat (4) tick();
      chk("stall marker_v_o", 0, 64'(mv), 64'h1);
      vin = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall hold marker_v_o", 0, 64'(mv), 64'h1);
         chk("stall valid_o", 0, 64'(vout), 64'h0);
      end
      vin = 1'b1;
      tick();
      chk("stall marker data", 0, dout[63:0], 64'hF7B8896F08477690);
      chk("stall marker drop", 0, 64'(mv), 64'h0);
      tick();
      chk("post-marker head", 0, 64'(hout[1:0]), 64'h2);

      // Reset mid-period after two data slots; reset beats valid_i.
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid reset marker_v_o", 0, 64'(mv), 64'h0);
      chk("mid reset valid_o", 0, 64'(vout), 64'h0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("restart marker_v_o", 0, 64'(mv), (i == 3) ? 64'h1 : 64'h0);
      end
      tick();
      chk("restart marker data", 0, dout[63:0], 64'hFFB8896F00477690);

      // Randomized traffic with random gaps in valid_i.
      for (int c = 0; c < 800; c++) begin
         vin = ($urandom_range(0, 3) != 0);
         for (int l = 0; l < LANE_N; l++) begin
            hin[l*2 +: 2]   = 2'($urandom);
            din[l*64 +: 64] = {$urandom, $urandom};
         end
         tick();
      end
      vin = 1'b0;
      tick();
      tick();
      @(negedge clk);
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
